// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status flowing in (master side drives it),
// segment-register stall/flush, redirect and performance counters flowing out.
interface pipeline_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [1:0]       RegReadD;
    logic [4:0]       RdE;
    logic             MemToRegE;
    logic [2:0]       RegWriteE;
    logic             CtrlE;
    logic             TakenE;
    logic [XLEN-1:0]  TargetE;
    logic [XLEN-1:0]  PCE;
    logic             BTBE;
    logic [XLEN-1:0]  PPCE;
    logic             DMissM;
    logic             DReadyM;
    logic             CntClr;

    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic             RedirectValid;
    logic [XLEN-1:0]  RedirectPC;
    logic [CNT_W-1:0] MispredCnt;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output Rs1D, Rs2D, RegReadD, RdE, MemToRegE, RegWriteE, CtrlE, TakenE,
               TargetE, PCE, BTBE, PPCE, DMissM, DReadyM, CntClr,
        input  StallF, StallD, StallE, StallM, StallW,
               FlushD, FlushE, FlushM, FlushW,
               RedirectValid, RedirectPC, MispredCnt, StallCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RegReadD, RdE, MemToRegE, RegWriteE, CtrlE, TakenE,
               TargetE, PCE, BTBE, PPCE, DMissM, DReadyM, CntClr,
        output StallF, StallD, StallE, StallM, StallW,
               FlushD, FlushE, FlushM, FlushW,
               RedirectValid, RedirectPC, MispredCnt, StallCnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// EX-resolved BTB mispredict redirects, D-cache miss wait sequencing, perf counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state;
    logic             load_use;
    logic             mispred;
    logic             hold;
    logic             redirect;
    logic             bubble;
    logic [CNT_W-1:0] mispred_cnt;
    logic [CNT_W-1:0] stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        load_use = hz.MemToRegE && (hz.RegWriteE != 3'd0) && (hz.RdE != 5'd0) &&
                   ((hz.RegReadD[1] && (hz.Rs1D == hz.RdE)) ||
                    (hz.RegReadD[0] && (hz.Rs2D == hz.RdE)));
        mispred  = hz.CtrlE &&
                   ((hz.TakenE && (!hz.BTBE || (hz.PPCE != hz.TargetE))) ||
                    (!hz.TakenE && hz.BTBE));
        // A pending miss freezes EX, so hazards there are re-judged once it is released.
        hold     = (state == RUN) ? hz.DMissM : !hz.DReadyM;
        redirect = !hold && mispred;
        bubble   = !hold && !mispred && load_use;
    end

    // Reset bubbles every segment, since the segment registers have no reset of their own.
    always_comb begin
        hz.StallW = 1'b0;
        hz.FlushM = 1'b0;
        if (!rst_n) begin
            hz.StallF        = 1'b0;
            hz.StallD        = 1'b0;
            hz.StallE        = 1'b0;
            hz.StallM        = 1'b0;
            hz.FlushD        = 1'b1;
            hz.FlushE        = 1'b1;
            hz.FlushM        = 1'b1;
            hz.FlushW        = 1'b1;
            hz.RedirectValid = 1'b0;
            hz.RedirectPC    = '0;
        end else begin
            hz.StallF        = hold || bubble;
            hz.StallD        = hold || bubble;
            hz.StallE        = hold;
            hz.StallM        = hold;
            hz.FlushD        = redirect;
            hz.FlushE        = redirect || bubble;
            hz.FlushW        = hold;
            hz.RedirectValid = redirect;
            hz.RedirectPC    = hz.TakenE ? hz.TargetE : hz.PCE + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (hz.DMissM) state <= MEM_WAIT;
        end else begin
            if (hz.DReadyM) state <= RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
            stall_cnt   <= '0;
        end else if (hz.CntClr) begin
            mispred_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (redirect)         mispred_cnt <= sat_inc(mispred_cnt);
            if (hold || bubble)   stall_cnt   <= sat_inc(stall_cnt);
        end
    end

    assign hz.MispredCnt = mispred_cnt;
    assign hz.StallCnt   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed hazard scenarios then randomized traffic, driving a
// 32-bit-counter and a 4-bit-counter controller from the same inputs.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.XLEN(32), .CNT_W(32)) h32();
    pipeline_hazard_ctrl_if #(.XLEN(32), .CNT_W(4))  h4();

    assign h4.Rs1D      = h32.Rs1D;
    assign h4.Rs2D      = h32.Rs2D;
    assign h4.RegReadD  = h32.RegReadD;
    assign h4.RdE       = h32.RdE;
    assign h4.MemToRegE = h32.MemToRegE;
    assign h4.RegWriteE = h32.RegWriteE;
    assign h4.CtrlE     = h32.CtrlE;
    assign h4.TakenE    = h32.TakenE;
    assign h4.TargetE   = h32.TargetE;
    assign h4.PCE       = h32.PCE;
    assign h4.BTBE      = h32.BTBE;
    assign h4.PPCE      = h32.PPCE;
    assign h4.DMissM    = h32.DMissM;
    assign h4.DReadyM   = h32.DReadyM;
    assign h4.CntClr    = h32.CntClr;

    pipeline_hazard_ctrl #(.CNT_W(32), .XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .hz(h32));
    pipeline_hazard_ctrl #(.CNT_W(4),  .XLEN(32)) dut4  (.clk(clk), .rst_n(rst_n), .hz(h4));

    typedef struct packed {
        logic [4:0]  stall;   // F D E M W
        logic [3:0]  flush;   // D E M W
        logic        rv;
        logic        chk_pc;
        logic [31:0] rpc;
        logic [31:0] mc;
        logic [31:0] sc;
        logic [3:0]  mc4;
        logic [3:0]  sc4;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: is a data-cache miss outstanding, plus counter images.
    bit          m_wait = 0;
    logic [31:0] m_mc = 0, m_sc = 0;
    int          m_mc4 = 0, m_sc4 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        bit lu, mp, miss_hold, sf, red;
        e = '0;
        lu = h32.MemToRegE && (h32.RegWriteE != 0) && (h32.RdE != 0) &&
             ((h32.RegReadD[1] && h32.Rs1D == h32.RdE) || (h32.RegReadD[0] && h32.Rs2D == h32.RdE));
        mp = h32.CtrlE && (h32.TakenE ? (!h32.BTBE || h32.PPCE != h32.TargetE) : h32.BTBE);
        if (!rst_n) begin
            m_wait = 0; m_mc = 0; m_sc = 0; m_mc4 = 0; m_sc4 = 0;
            e.flush = 4'b1111;
            e.chk_pc = 1;
            e.rpc = 0;
        end else begin
            miss_hold = m_wait ? !h32.DReadyM : h32.DMissM;
            red = !miss_hold && mp;
            sf  = miss_hold || (!mp && lu);
            if (miss_hold)     begin e.stall = 5'b11110; e.flush = 4'b0001; end
            else if (mp)       begin e.flush = 4'b1100; e.rv = 1; end
            else if (lu)       begin e.stall = 5'b11000; e.flush = 4'b0100; end
            e.chk_pc = red;
            e.rpc = h32.TakenE ? h32.TargetE : h32.PCE + 32'd4;
            e.mc = m_mc; e.sc = m_sc; e.mc4 = 4'(m_mc4); e.sc4 = 4'(m_sc4);
            if (h32.CntClr) begin
                m_mc = 0; m_sc = 0; m_mc4 = 0; m_sc4 = 0;
            end else begin
                if (red && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
                if (sf  && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
                if (red && m_mc4 < 15) m_mc4++;
                if (sf  && m_sc4 < 15) m_sc4++;
            end
            m_wait = m_wait ? !h32.DReadyM : h32.DMissM;
        end
        q.push_back(e);
    endtask

    task automatic idle();
        rst_n = 1; h32.Rs1D = 0; h32.Rs2D = 0; h32.RegReadD = 0; h32.RdE = 0;
        h32.MemToRegE = 0; h32.RegWriteE = 0; h32.CtrlE = 0; h32.TakenE = 0;
        h32.TargetE = 0; h32.PCE = 0; h32.BTBE = 0; h32.PPCE = 0;
        h32.DMissM = 0; h32.DReadyM = 0; h32.CntClr = 0;
    endtask

    task automatic cyc();
        push_expect();
        @(posedge clk); #1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        h32.MemToRegE = 1; h32.RegWriteE = 3'd1; h32.RdE = rd; h32.Rs1D = 5; h32.RegReadD = 2'b10;
    endtask

    task automatic set_br(input bit taken, input bit btb, input logic [31:0] ppc,
                          input logic [31:0] tgt, input logic [31:0] pc);
        h32.CtrlE = 1; h32.TakenE = taken; h32.BTBE = btb; h32.PPCE = ppc;
        h32.TargetE = tgt; h32.PCE = pc;
    endtask

    // Monitor: outputs are presented every cycle; check each mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall32", 64'({h32.StallF, h32.StallD, h32.StallE, h32.StallM, h32.StallW}), 64'(e.stall));
                chk("flush32", 64'({h32.FlushD, h32.FlushE, h32.FlushM, h32.FlushW}), 64'(e.flush));
                chk("stall4",  64'({h4.StallF, h4.StallD, h4.StallE, h4.StallM, h4.StallW}), 64'(e.stall));
                chk("flush4",  64'({h4.FlushD, h4.FlushE, h4.FlushM, h4.FlushW}), 64'(e.flush));
                chk("redirect_valid", 64'(h32.RedirectValid), 64'(e.rv));
                if (e.chk_pc) chk("redirect_pc", 64'(h32.RedirectPC), 64'(e.rpc));
                chk("mispred_cnt32", 64'(h32.MispredCnt), 64'(e.mc));
                chk("stall_cnt32",   64'(h32.StallCnt),   64'(e.sc));
                chk("mispred_cnt4",  64'(h4.MispredCnt),  64'(e.mc4));
                chk("stall_cnt4",    64'(h4.StallCnt),    64'(e.sc4));
            end
        end
    end

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        repeat (3) cyc();
        idle(); cyc(); cyc();

        set_lu(5'd5); cyc(); idle(); cyc();
        set_lu(5'd0); cyc(); idle(); cyc();

        set_br(1, 1, 32'h100, 32'h200, 32'h80); cyc(); idle(); cyc();
        set_br(0, 1, 32'h0, 32'h300, 32'h40);   cyc(); idle(); cyc();
        set_br(1, 1, 32'h200, 32'h200, 32'h80); cyc(); idle(); cyc();

        h32.CntClr = 1; cyc(); idle();
        h32.DMissM = 1; cyc(); idle();
        repeat (3) cyc();
        h32.DReadyM = 1; cyc(); idle(); cyc();

        h32.DMissM = 1; set_br(1, 0, 32'h0, 32'h500, 32'h10); cyc();
        h32.DMissM = 0; cyc(); cyc();
        h32.DReadyM = 1; cyc(); idle(); cyc();

        set_br(1, 0, 32'h0, 32'h600, 32'h20); set_lu(5'd5); cyc(); idle(); cyc();

        set_lu(5'd7); h32.Rs1D = 7;
        repeat (20) cyc();
        h32.CntClr = 1; cyc(); idle(); cyc();

        h32.DMissM = 1; cyc(); idle(); cyc();
        rst_n = 0; cyc(); idle(); cyc();

        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            h32.Rs1D      = 5'($urandom_range(0, 3));
            h32.Rs2D      = 5'($urandom_range(0, 3));
            h32.RegReadD  = 2'($urandom_range(0, 3));
            h32.RdE       = 5'($urandom_range(0, 3));
            h32.MemToRegE = 1'($urandom_range(0, 1));
            h32.RegWriteE = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            h32.CtrlE     = 1'($urandom_range(0, 1));
            h32.TakenE    = 1'($urandom_range(0, 1));
            h32.BTBE      = 1'($urandom_range(0, 1));
            h32.TargetE   = $urandom;
            h32.PCE       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            h32.PPCE      = $urandom_range(0, 1) ? h32.TargetE : $urandom;
            h32.DMissM    = ($urandom_range(0, 9) == 0);
            h32.DReadyM   = ($urandom_range(0, 2) == 0);
            h32.CntClr    = ($urandom_range(0, 99) == 0);
            cyc();
        end
        idle();
        @(negedge clk); @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline, including the BTB-augmented ID/EX stage.
- Drives the en/clear pins of the IF, ID, EX, MEM and WB segment registers.
- Detects load-use hazards and BTB mispredictions resolved in EX.
- Sequences data-cache miss wait states through a small FSM.
- Keeps saturating performance counters for mispredictions and stall cycles.

Parameters:
CNT_W, 32, width of each performance counter
XLEN, 32, PC width

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
Rs1D  in  5  ID source register 1
Rs2D  in  5  ID source register 2
RegReadD  in  2  bit1: Rs1 used, bit0: Rs2 used
RdE  in  5  EX destination register
MemToRegE  in  1  EX instruction is a load
RegWriteE  in  3  EX write type; nonzero means the instruction writes Rd
CtrlE  in  1  EX holds a branch or jalr (valid, not a bubble)
TakenE  in  1  resolved direction in EX
TargetE  in  XLEN  resolved target in EX
PCE  in  XLEN  EX PC
BTBE  in  1  BTB hit travelling with the EX instruction
PPCE  in  XLEN  predicted PC travelling with the EX instruction
DMissM  in  1  data cache miss in MEM
DReadyM  in  1  data cache refill complete
CntClr  in  1  synchronous counter clear
StallF, StallD, StallE, StallM, StallW  out  1 each  segment hold (en = ~Stall)
FlushD, FlushE, FlushM, FlushW  out  1 each  segment clear
RedirectValid  out  1  fetch must load RedirectPC
RedirectPC  out  XLEN  corrected fetch PC
MispredCnt  out  CNT_W  mispredictions redirected
StallCnt  out  CNT_W  cycles with StallF=1

Behaviour:
Reset (rst_n=0, asynchronous):
- FSM=RUN; counters=0.
- All Flush*=1, all Stall*=0, RedirectValid=0, RedirectPC=0.
- Segment registers have no reset of their own; the controller bubbles them.

Definitions (combinational):
- LoadUse = MemToRegE & (RegWriteE!=0) & (RdE!=0) & ((RegReadD[1]&Rs1D==RdE) | (RegReadD[0]&Rs2D==RdE)).
- Mispred = CtrlE & ((TakenE & (~BTBE | PPCE!=TargetE)) | (~TakenE & BTBE)).
- RedirectPC = TakenE ? TargetE : PCE+4, modulo 2^XLEN.

FSM states: RUN, MEM_WAIT.

RUN:
- DMissM=1: StallF/D/E/M=1, FlushW=1, RedirectValid=0, no other flush; next state MEM_WAIT. This has highest priority: Mispred and LoadUse are ignored this cycle and re-evaluated later from the held EX.
- Else Mispred=1: RedirectValid=1, FlushD=1, FlushE=1, all stalls 0. LoadUse is suppressed because the dependent instruction is being flushed. MispredCnt increments.
- Else LoadUse=1: StallF=StallD=1, FlushE=1, all other outputs 0. Exactly one bubble per load-use.
- Else: all outputs 0.

MEM_WAIT:
- DReadyM=0: StallF/D/E/M=1, FlushW=1.
- DReadyM=1: same-cycle release. Stalls=0, FlushW=0, so MEM advances into WB. Mispred and LoadUse are evaluated as in RUN this cycle. Next state RUN.
- DMissM is ignored while in MEM_WAIT.

Invariants:
- StallW is always 0.
- FlushM is 0 in all cases; it is reserved for exceptions.
- A flushed stage is never simultaneously stalled.
- A misprediction is counted only in a cycle where EX is not stalled, so each EX instruction is counted at most once.

Counters:
- Sequential, saturating at all-ones; no wrap.
- CntClr=1 zeroes both counters, taking priority over increment.
- StallCnt increments on every cycle with StallF=1.
- Reset mid-wait: FSM returns to RUN immediately and all stages are flushed.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → Flush*=1, Stall*=0, counters 0. Release → all outputs 0 with idle inputs.
- Load-use: MemToRegE=1, RegWriteE=1, RdE=5, Rs1D=5, RegReadD=2'b10 → one cycle StallF=StallD=FlushE=1, StallCnt=1. Repeat with RdE=0 → no stall.
- Mispredict: CtrlE=1, TakenE=1, BTBE=1, PPCE=0x100, TargetE=0x200 → RedirectValid=1, RedirectPC=0x200, FlushD=FlushE=1, MispredCnt=1. With CtrlE=1, TakenE=0, BTBE=1, PCE=0x40 → RedirectPC=0x44. Correct hit (PPCE=TargetE) → no redirect.
- Cache miss: DMissM=1 for 1 cycle, DReadyM=1 at cycle 4 → StallF..M=1 and FlushW=1 for cycles 0-3, released in cycle 4, StallCnt=4.
- Simultaneous: DMissM=1 together with Mispred → no redirect until the DReadyM cycle, then one redirect, MispredCnt incremented once. Mispred plus LoadUse → redirect only, no stall.
- Saturation/clear: preload StallCnt near all-ones (CNT_W=4 build) → holds at 15. CntClr together with a stall cycle → 0.
